// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial two's-complement subtractor: computes a - b - bin one bit per
// clock, LSB first, through a single full-subtractor cell. Operands arrive
// and results leave over valid/ready handshakes. Intended as the small,
// latency-tolerant subtract path of the FP datapath.
module serial_subtractor #(
  parameter int WIDTH     = 8,
  parameter int IMPL_TYPE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_bout,
  output logic             out_ovf
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Operand shift registers; bit 0 feeds the cell each RUN cycle.
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  // Difference bits produced so far, newest at the MSB. Only WIDTH-1 bits
  // are kept: the final bit comes straight from the cell on the last edge.
  logic [WIDTH-2:0] res_q;
  logic [WIDTH-1:0] res_full;

  logic             borrow_q;
  logic [CNT_W-1:0] cnt_q;
  logic             a_msb_q;
  logic             b_msb_q;

  logic [WIDTH-1:0] out_diff_q;
  logic             out_bout_q;
  logic             out_ovf_q;

  logic cell_diff;
  logic cell_bout;
  logic accept;
  logic last_bit;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Full-subtractor cell, selectable implementation. Both variants are
  // bit-identical; they differ only in the gate structure they map to.
  generate
    if (WIDTH < 2) begin : g_bad_width
      $fatal(1, "serial_subtractor: WIDTH must be at least 2");
    end

    if (IMPL_TYPE == 0) begin : g_xor_mux
      // When a and b differ the borrow is decided by b alone (0-1 borrows,
      // 1-0 does not); when they match the incoming borrow propagates.
      logic a_xor_b;
      assign a_xor_b   = sa_q[0] ^ sb_q[0];
      assign cell_bout = a_xor_b ? sb_q[0] : borrow_q;
      assign cell_diff = a_xor_b ^ borrow_q;
    end else if (IMPL_TYPE == 1) begin : g_maj
      // Subtraction is addition of ~a with b and bin: the borrow is the
      // majority of the three, and the parity is rebuilt from two further
      // majority gates (sum = maj(~cout, cin, maj(x, y, ~cin))). Inverting
      // that parity of (~a, b, bin) gives a ^ b ^ bin.
      logic not_a;
      logic inner_maj;
      logic parity_n;
      assign not_a     = ~sa_q[0];
      assign cell_bout = maj3(not_a, sb_q[0], borrow_q);
      assign inner_maj = maj3(not_a, sb_q[0], ~borrow_q);
      assign parity_n  = maj3(~cell_bout, borrow_q, inner_maj);
      assign cell_diff = ~parity_n;
    end else begin : g_bad_impl
      $fatal(1, "serial_subtractor: IMPL_TYPE must be 0 or 1");
    end
  endgenerate

  assign accept   = in_valid && in_ready;
  assign last_bit = (state_q == S_RUN) && (cnt_q == LAST_BIT);
  assign res_full = {cell_diff, res_q};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept, count through WIDTH bits, then wait for the
  // consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_RUN;
      S_RUN:   if (last_bit)  state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of the state register.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Operand capture on accept, then one shift per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q    <= '0;
      sb_q    <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else if (accept) begin
      sa_q    <= in_a;
      sb_q    <= in_b;
      a_msb_q <= in_a[WIDTH-1];
      b_msb_q <= in_b[WIDTH-1];
    end else if (state_q == S_RUN) begin
      sa_q <= sa_q >> 1;
      sb_q <= sb_q >> 1;
    end
  end

  // Borrow chain and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (accept) begin
      borrow_q <= in_bin;
      cnt_q    <= '0;
    end else if (state_q == S_RUN) begin
      borrow_q <= cell_bout;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

  // Partial result: each new difference bit enters from the MSB side.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
    end else if (state_q == S_RUN) begin
      res_q <= res_full[WIDTH-1:1];
    end
  end

  // Result registers load on the last bit and hold until the next result;
  // an aborted operation never reaches this point.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_diff_q <= '0;
      out_bout_q <= 1'b0;
      out_ovf_q  <= 1'b0;
    end else if (last_bit) begin
      out_diff_q <= res_full;
      out_bout_q <= cell_bout;
      out_ovf_q  <= (a_msb_q != b_msb_q) && (cell_diff != a_msb_q);
    end
  end

  assign out_diff = out_diff_q;
  assign out_bout = out_bout_q;
  assign out_ovf  = out_ovf_q;

endmodule
